// File: rtl/can_host_bus_master_if.sv
`default_nettype none
//==============================================================================
// Module   : can_host_bus_master_if
// Brief    : Host request port plus multiplexed-AD controller pins of the CAN host bus master.
// Revision : 1.0 - initial release
//==============================================================================
interface can_host_bus_master_if #(
    parameter int DW  = 8,
    parameter int NCH = 2
);
    localparam int C_CHW = $clog2(NCH) + 1;

    logic              req;
    logic              we;
    logic [C_CHW-1:0]  chsel;
    logic [DW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              busy;

    logic [DW-1:0]     ad_o;
    logic              ad_oe;
    logic [DW-1:0]     ad_i;
    logic              ale;
    logic [NCH-1:0]    cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              mode;
    logic [NCH-1:0]    int_n;
    logic [NCH-1:0]    irq;

    modport master (
        input  req, we, chsel, addr, wdata, ad_i, int_n,
        output ack, err, rdata, busy, ad_o, ad_oe, ale, cs_n, rd_n, wr_n, mode, irq
    );

    modport slave (
        output req, we, chsel, addr, wdata, ad_i, int_n,
        input  ack, err, rdata, busy, ad_o, ad_oe, ale, cs_n, rd_n, wr_n, mode, irq
    );
endinterface
`default_nettype wire

// File: rtl/can_host_bus_master.sv
`default_nettype none
//==============================================================================
// Module   : can_host_bus_master
// Brief    : Intel-mode host bus master for SJA1000-class CAN controllers; optional
//            2-flop INT_N synchroniser enabled by CAN_HBM_INT_SYNC_EN.
// Revision : 1.0 - initial release
//==============================================================================
module can_host_bus_master #(
    parameter int DW    = 8,
    parameter int NCH   = 2,
    parameter int T_ALE = 2,
    parameter int T_WS  = 3,
    parameter int T_REC = 2
) (
    input wire                    clk_i,
    input wire                    rst_ni,
    can_host_bus_master_if.master bus
);
    localparam int C_CHW  = $clog2(NCH) + 1;
    localparam int C_TMAX = (T_ALE > T_WS) ? ((T_ALE > T_REC) ? T_ALE : T_REC)
                                           : ((T_WS > T_REC) ? T_WS : T_REC);
    localparam int C_CW   = $clog2(C_TMAX) + 1;

    localparam logic [C_CW-1:0]  C_ALE_LD = C_CW'(T_ALE - 1);
    localparam logic [C_CW-1:0]  C_WS_LD  = C_CW'(T_WS - 1);
    localparam logic [C_CW-1:0]  C_REC_LD = C_CW'(T_REC - 1);
    localparam logic [C_CW-1:0]  C_ONE    = C_CW'(1);
    localparam logic [C_CHW-1:0] C_NCH    = C_CHW'(NCH);
    localparam logic [NCH-1:0]   C_CS_ONE = NCH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_HOLD  = 3'd2,
        S_STRB  = 3'd3,
        S_RECOV = 3'd4
    } state_t;

    state_t           state_q;
    logic [C_CW-1:0]  cnt_q;
    logic             we_q;
    logic [C_CHW-1:0] ch_q;
    logic [DW-1:0]    wdata_q;
    logic             ack_q;
    logic             err_q;
    logic             busy_q;
    logic             ale_q;
    logic             ad_oe_q;
    logic [DW-1:0]    ad_o_q;
    logic [NCH-1:0]   cs_n_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic [DW-1:0]    rdata_q;
    logic [NCH-1:0]   irq_q;

    logic             start_d;
    logic [NCH-1:0]   cs_n_d;

    // The last recovery cycle also samples req, so a held request restarts T_REC cycles after ack.
    assign start_d = bus.req && ((state_q == S_IDLE) ||
                                 ((state_q == S_RECOV) && (cnt_q == '0)));
    assign cs_n_d  = ~(C_CS_ONE << ch_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ch_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ale_q   <= 1'b0;
            ad_oe_q <= 1'b0;
            ad_o_q  <= '0;
            cs_n_q  <= '1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (start_d) begin
                we_q    <= bus.we;
                ch_q    <= bus.chsel;
                wdata_q <= bus.wdata;
                busy_q  <= 1'b1;
                if (bus.chsel >= C_NCH) begin
                    state_q <= S_RECOV;
                    cnt_q   <= C_REC_LD;
                    ack_q   <= 1'b1;
                    err_q   <= 1'b1;
                end else begin
                    state_q <= S_ADDR;
                    cnt_q   <= C_ALE_LD;
                    ale_q   <= 1'b1;
                    ad_oe_q <= 1'b1;
                    ad_o_q  <= bus.addr;
                end
            end else begin
                case (state_q)
                    S_IDLE: busy_q <= 1'b0;
                    S_ADDR: begin
                        if (cnt_q == '0) begin
                            state_q <= S_HOLD;
                            ale_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - C_ONE;
                        end
                    end
                    S_HOLD: begin
                        state_q <= S_STRB;
                        cnt_q   <= C_WS_LD;
                        cs_n_q  <= cs_n_d;
                        if (we_q) begin
                            wr_n_q <= 1'b0;
                            ad_o_q <= wdata_q;
                        end else begin
                            rd_n_q  <= 1'b0;
                            ad_oe_q <= 1'b0;
                        end
                    end
                    S_STRB: begin
                        if (cnt_q == '0) begin
                            if (!we_q) begin
                                rdata_q <= bus.ad_i;
                            end
                            state_q <= S_RECOV;
                            cnt_q   <= C_REC_LD;
                            cs_n_q  <= '1;
                            rd_n_q  <= 1'b1;
                            wr_n_q  <= 1'b1;
                            ad_oe_q <= 1'b0;
                            ack_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - C_ONE;
                        end
                    end
                    S_RECOV: begin
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - C_ONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CAN_HBM_INT_SYNC_EN
    logic [NCH-1:0] int_meta_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            int_meta_q <= '0;
            irq_q      <= '0;
        end else begin
            int_meta_q <= ~bus.int_n;
            irq_q      <= int_meta_q;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= '0;
        end else begin
            irq_q <= ~bus.int_n;
        end
    end
`endif

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.ad_o  = ad_o_q;
    assign bus.ad_oe = ad_oe_q;
    assign bus.ale   = ale_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.rd_n  = rd_n_q;
    assign bus.wr_n  = wr_n_q;
    assign bus.mode  = 1'b1;
    assign bus.irq   = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_can_host_bus_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_can_host_bus_master
// Brief    : Randomised self-checking bench with a cycle-timeline reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_can_host_bus_master;
    localparam int DW    = 8;
    localparam int NCH   = 2;
    localparam int T_ALE = 2;
    localparam int T_WS  = 3;
    localparam int T_REC = 2;
    localparam int CHW   = $clog2(NCH) + 1;
    localparam int LA    = T_ALE + T_WS + 2;
`ifdef CAN_HBM_INT_SYNC_EN
    localparam int IRQ_LAG = 2;
`else
    localparam int IRQ_LAG = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    int            n_total = 0;
    int            n_bad   = 0;
    logic [DW-1:0] mdl_rdata;

    can_host_bus_master_if #(.DW(DW), .NCH(NCH)) bus ();

    can_host_bus_master #(
        .DW(DW), .NCH(NCH), .T_ALE(T_ALE), .T_WS(T_WS), .T_REC(T_REC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic ale, input logic oe, input logic [NCH-1:0] cs,
                                         input logic rd, input logic wr, input logic bsy,
                                         input logic ak, input logic er);
        return 32'({ale, oe, cs, rd, wr, bsy, ak, er});
    endfunction

    function automatic logic [31:0] ctl_obs();
        return pack(bus.ale, bus.ad_oe, bus.cs_n, bus.rd_n, bus.wr_n, bus.busy, bus.ack, bus.err);
    endfunction

    // One request from acceptance to the end of recovery, every cycle checked against the timeline.
    task automatic run_txn(input logic w, input int ch, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input bit fix_en, input logic [DW-1:0] fix_v, input bit hold, input int gap);
        bit             bad_ch;
        int             kend;
        int             ack_k;
        int             strb_lo;
        int             strb_hi;
        logic [DW-1:0]  v;
        logic [DW-1:0]  cap_v;
        logic           e_ale, e_oe, e_rd, e_wr, e_ak, e_er;
        logic [NCH-1:0] e_cs;
        bad_ch  = (ch >= NCH);
        kend    = bad_ch ? T_REC : (LA + T_REC - 1);
        ack_k   = bad_ch ? 1 : LA;
        strb_lo = T_ALE + 2;
        strb_hi = T_ALE + 1 + T_WS;
        cap_v   = '0;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.chsel = CHW'(ch);
        bus.addr  = a;
        bus.wdata = d;
        tick();
        for (int k = 1; k <= kend; k++) begin
            e_ale = 1'b0; e_oe = 1'b0; e_rd = 1'b1; e_wr = 1'b1; e_cs = '1;
            if (!bad_ch && k <= T_ALE) begin
                e_ale = 1'b1;
                e_oe  = 1'b1;
                chk($sformatf("addr_phase k=%0d", k), bus.ad_o, a);
            end else if (!bad_ch && k == T_ALE + 1) begin
                e_oe = 1'b1;
                chk("addr_hold", bus.ad_o, a);
            end else if (!bad_ch && k >= strb_lo && k <= strb_hi) begin
                e_cs[ch] = 1'b0;
                if (w) begin
                    e_wr = 1'b0;
                    e_oe = 1'b1;
                    chk($sformatf("wdata k=%0d", k), bus.ad_o, d);
                end else begin
                    e_rd = 1'b0;
                end
            end
            e_ak = (k == ack_k);
            e_er = e_ak && bad_ch;
            if (e_ak && !bad_ch && !w) mdl_rdata = cap_v;
            chk($sformatf("ctl k=%0d ch=%0d we=%0d", k, ch, w), ctl_obs(),
                pack(e_ale, e_oe, e_cs, e_rd, e_wr, 1'b1, e_ak, e_er));
            chk($sformatf("rdata k=%0d", k), bus.rdata, mdl_rdata);
            v = fix_en ? fix_v : DW'($urandom);
            bus.ad_i = v;
            if (k == strb_hi) cap_v = v;
            if (e_ak && !hold) bus.req = 1'b0;
            if (k < kend) tick();
        end
        if (!hold) begin
            for (int g = 0; g <= gap; g++) begin
                tick();
                chk("idle", ctl_obs(), pack(1'b0, 1'b0, '1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    initial begin
        logic [NCH-1:0] hist[$];
        logic [NCH-1:0] nv;
        logic [NCH-1:0] e_irq;
        logic           r_w;
        int             r_ch;
        bit             r_hold;
        int             r_gap;

        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.chsel = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.ad_i  = '0;
        bus.int_n = '1;
        mdl_rdata = '0;
        repeat (3) tick();
        chk("reset_ctl", ctl_obs(), pack(1'b0, 1'b0, '1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("reset_ad_o", bus.ad_o, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_irq", bus.irq, 0);
        chk("mode", bus.mode, 1);
        rst_n = 1'b1;
        tick();

        run_txn(1'b1, 1, 8'h04, 8'hA5, 1'b0, 8'h00, 1'b0, 2);
        run_txn(1'b0, 0, 8'h02, 8'h00, 1'b1, 8'h3C, 1'b0, 1);
        run_txn(1'b0, 2, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1);
        run_txn(1'b1, 0, 8'h20, 8'h5A, 1'b0, 8'h00, 1'b1, 0);
        run_txn(1'b0, 1, 8'h21, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        run_txn(1'b0, 3, 8'h22, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        run_txn(1'b1, 1, 8'h23, 8'hC3, 1'b0, 8'h00, 1'b0, 0);

        // Reset asserted during the strobe of a write to channel 0.
        bus.req = 1'b1; bus.we = 1'b1; bus.chsel = '0; bus.addr = 8'h30; bus.wdata = 8'h77;
        tick();
        repeat (T_ALE + 1) tick();
        chk("pre_rst_strobe", ctl_obs(), pack(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        bus.req = 1'b0;
        rst_n   = 1'b0;
        repeat (3) begin
            tick();
            chk("mid_rst", ctl_obs(), pack(1'b0, 1'b0, '1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        rst_n     = 1'b1;
        mdl_rdata = '0;
        repeat (3) begin
            tick();
            chk("post_rst", ctl_obs(), pack(1'b0, 1'b0, '1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            chk("post_rst_rdata", bus.rdata, mdl_rdata);
        end

        // Interrupt path: expected irq is the inverted INT_N seen IRQ_LAG edges earlier.
        for (int i = 0; i < IRQ_LAG; i++) hist.push_back('1);
        for (int j = 0; j < 60; j++) begin
            e_irq = ~hist[hist.size() - IRQ_LAG];
            chk($sformatf("irq j=%0d", j), bus.irq, e_irq);
            if (j < 4)       nv = '1;
            else if (j < 10) nv = 2'b01;
            else if (j < 16) nv = '1;
            else             nv = NCH'($urandom);
            bus.int_n = nv;
            hist.push_back(nv);
            tick();
        end
        bus.int_n = '1;

        for (int t = 0; t < 40; t++) begin
            r_w    = 1'($urandom_range(0, 1));
            r_ch   = $urandom_range(0, 3);
            r_hold = (t < 39) && ($urandom_range(0, 1) == 1);
            r_gap  = $urandom_range(0, 3);
            run_txn(r_w, r_ch, DW'($urandom), DW'($urandom), 1'b0, 8'h00, r_hold, r_gap);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
